// File: rtl/srl_dly_cal.sv
// srl_dly_cal: measures an SRL delay path with repeated test pulses and derives the matching SRL address
module srl_dly_cal #(
    parameter int AW    = 4,
    parameter int NPASS = 4,
    parameter int GAP   = 4
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic          START,
    input  logic          PULSE_RTN,
    output logic          PULSE_OUT,
    output logic [AW-1:0] A_OUT,
    output logic          BUSY,
    output logic          DONE,
    output logic [1:0]    ERR
);
    localparam int CW = AW + 1;
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [CW-1:0] MAXD = CW'(2 ** AW);

    typedef enum logic [2:0] {S_IDLE, S_SEND, S_WAIT, S_GAP, S_FIN} state_t;

    state_t        r_state, w_nxt;
    logic [CW-1:0] r_cnt, r_meas, w_cnt_inc;
    logic [3:0]    r_pass, w_pass_inc;
    logic [GW-1:0] r_gcnt;
    logic [AW-1:0] r_a, w_a_n;
    logic [1:0]    r_err, w_err_n;
    logic          r_busy, r_done;
    logic          w_tmo, w_rtn, w_mis, w_last, w_spur, w_gend;

    assign w_cnt_inc  = r_cnt + CW'(1);
    assign w_pass_inc = r_pass + 4'd1;
    assign w_tmo      = (r_state == S_WAIT) && CE && (w_cnt_inc > MAXD);
    assign w_rtn      = (r_state == S_WAIT) && CE && PULSE_RTN && !w_tmo;
    assign w_mis      = w_rtn && (r_pass != 4'd0) && (w_cnt_inc != r_meas);
    assign w_last     = w_pass_inc == 4'(NPASS);
    assign w_spur     = (r_state == S_GAP) && PULSE_RTN;
    assign w_gend     = r_gcnt == GW'(GAP - 1);

    // the launch pulse must coincide with the CE edge the delay line samples on
    assign PULSE_OUT = (r_state == S_SEND) && CE;
    assign A_OUT     = r_a;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign ERR       = r_err;

    // state register
    always_ff @(posedge CLK) begin
        r_state <= RST ? S_IDLE : w_nxt;
    end

    // next-state decode
    always_comb begin
        w_nxt = r_state;
        case (r_state)
            S_IDLE:  w_nxt = START ? S_SEND : S_IDLE;
            S_SEND:  w_nxt = CE ? S_WAIT : S_SEND;
            S_WAIT:  w_nxt = (w_tmo || w_mis || (w_rtn && w_last)) ? S_FIN : w_rtn ? S_GAP : S_WAIT;
            S_GAP:   w_nxt = w_spur ? S_FIN : w_gend ? S_SEND : S_GAP;
            default: w_nxt = S_IDLE;
        endcase
    end

    // next values of the registered outputs
    always_comb begin
        w_err_n = ((r_state == S_IDLE) && START) ? 2'b00 :
                  w_tmo  ? 2'b01 :
                  w_mis  ? 2'b10 :
                  w_spur ? 2'b11 : r_err;
        w_a_n   = ((r_state == S_FIN) && (r_err == 2'b00)) ? r_meas[AW-1:0] - AW'(1) : r_a;
    end

    // counters, measurement and output registers
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt  <= '0;
            r_meas <= '0;
            r_pass <= '0;
            r_gcnt <= '0;
            r_a    <= '0;
            r_err  <= '0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_cnt  <= ((r_state == S_SEND) && CE) ? '0 : ((r_state == S_WAIT) && CE) ? w_cnt_inc : r_cnt;
            r_meas <= (w_rtn && (r_pass == 4'd0)) ? w_cnt_inc : r_meas;
            r_pass <= ((r_state == S_IDLE) && START) ? 4'd0 : (w_rtn && !w_mis) ? w_pass_inc : r_pass;
            r_gcnt <= (r_state == S_GAP) ? r_gcnt + GW'(1) : '0;
            r_a    <= w_a_n;
            r_err  <= w_err_n;
            r_busy <= w_nxt != S_IDLE;
            r_done <= w_nxt == S_FIN;
        end
    end
endmodule

// File: tb/tb_srl_dly_cal.sv
// tb_srl_dly_cal: drives srl_dly_cal through an SRL model and behavioural returns, scoreboarding each calibration result
module tb_srl_dly_cal;
    localparam int AW = 4, NPASS = 4, GAP = 4;

    logic          CLK = 1'b0, RST = 1'b1, CE = 1'b1, START = 1'b0;
    logic          PULSE_OUT, BUSY, DONE, PULSE_RTN;
    logic [AW-1:0] A_OUT;
    logic [1:0]    ERR;

    logic [15:0] srl = '0;
    logic [3:0]  a = '0;
    logic        use_srl = 1'b1, rtn_inj = 1'b0, ce_tog = 1'b0;
    int          n_launch = 0, l0 = 0, n_pass = 0, n_tot = 0, last_a = 0, n;

    typedef struct { int err; int a; int launches; } exp_t;
    typedef struct { logic [3:0] a; bit tog; } vec_t;
    exp_t sb[$];
    vec_t tbl[18];

    srl_dly_cal #(.AW(AW), .NPASS(NPASS), .GAP(GAP)) dut (
        .CLK(CLK), .RST(RST), .CE(CE), .START(START), .PULSE_RTN(PULSE_RTN),
        .PULSE_OUT(PULSE_OUT), .A_OUT(A_OUT), .BUSY(BUSY), .DONE(DONE), .ERR(ERR)
    );

    assign PULSE_RTN = (use_srl && srl[a]) || rtn_inj;

    always #5 CLK = ~CLK;

    always @(posedge CLK) srl <= RST ? 16'h0 : CE ? {srl[14:0], PULSE_OUT} : srl;

    always @(negedge CLK) if (PULSE_OUT) n_launch <= n_launch + 1;

    initial forever begin
        @(posedge CLK);
        #1 CE = ce_tog ? ~CE : 1'b1;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_tot++;
        if (act != exp) $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic cyc(input int k);
        repeat (k) begin @(posedge CLK); #1; end
    endtask

    task automatic start1();
        @(posedge CLK); #1 START = 1'b1;
        @(posedge CLK); #1 START = 1'b0;
    endtask

    task automatic launch(input exp_t e);
        sb.push_back(e);
        l0 = n_launch;
        start1();
    endtask

    task automatic wait_launch();
        int k = 0;
        while (k < 200) begin @(negedge CLK); k++; if (PULSE_OUT) break; end
        chk("launch_seen", PULSE_OUT, 1);
    endtask

    task automatic bret(input int d);
        wait_launch();
        repeat (d) @(posedge CLK);
        #1 rtn_inj = 1'b1;
        @(posedge CLK); #1 rtn_inj = 1'b0;
    endtask

    task automatic finish_cal(input int budget, output int cnt);
        exp_t e;
        cnt = 0;
        while (cnt < budget) begin @(negedge CLK); cnt++; if (DONE) break; end
        chk("done_seen", DONE, 1);
        if (DONE) begin
            chk("sb_nonempty", sb.size(), 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("err_at_done", ERR, e.err);
                chk("busy_at_done", BUSY, 1);
                chk("launches", n_launch - l0, e.launches);
                @(negedge CLK);
                chk("a_out", A_OUT, e.a);
                chk("done_fall", DONE, 0);
                chk("busy_fall", BUSY, 0);
            end
        end
    endtask

    initial begin
        tbl[0] = '{4'd4, 1'b0};
        for (int i = 0; i < 16; i++) tbl[i+1] = '{4'(i), 1'b1};
        tbl[17] = '{4'd7, 1'b0};

        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_pulse", PULSE_OUT, 0);
        chk("rst_a", A_OUT, 0);
        chk("rst_err", ERR, 0);

        for (int i = 0; i < 18; i++) begin
            a = tbl[i].a;
            ce_tog = tbl[i].tog;
            use_srl = 1'b1;
            cyc(2);
            launch('{0, int'(tbl[i].a), NPASS});
            finish_cal(600, n);
            last_a = int'(tbl[i].a);
        end

        use_srl = 1'b0;
        ce_tog = 1'b0;
        cyc(2);
        launch('{1, last_a, 1});
        finish_cal(100, n);
        chk("tmo_cycles", n, 19);

        launch('{2, last_a, 2});
        bret(5);
        bret(6);
        finish_cal(100, n);

        launch('{3, last_a, 1});
        bret(5);
        cyc(1);
        rtn_inj = 1'b1;
        cyc(1);
        rtn_inj = 1'b0;
        finish_cal(100, n);

        use_srl = 1'b1;
        a = 4'd4;
        cyc(2);
        start1();
        repeat (3) wait_launch();
        cyc(2);
        RST = 1'b1;
        cyc(1);
        RST = 1'b0;
        @(negedge CLK);
        chk("mid_rst_busy", BUSY, 0);
        chk("mid_rst_pulse", PULSE_OUT, 0);
        chk("mid_rst_a", A_OUT, 0);
        chk("mid_rst_err", ERR, 0);
        chk("mid_rst_done", DONE, 0);

        a = 4'd2;
        cyc(2);
        launch('{0, 2, NPASS});
        finish_cal(200, n);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
